// File: rtl/t01_ai_cand_sched.sv
// rtl/t01_ai_cand_sched.sv - Tetris AI candidate scheduler: walks every (rotation, X) placement through the MMU
module t01_ai_cand_sched #(
    parameter int NUM_X   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] shape_i,
    input  logic       mmu_done,
    output logic       mmu_start,
    output logic [3:0] cand_blockX,
    output logic [4:0] cand_block_type,
    output logic       ofm_clear,
    output logic       busy,
    output logic       sched_done,
    output logic       err,
    output logic [5:0] cand_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t     state;
    logic [2:0] shape_r;
    logic [1:0] rot;
    logic [3:0] x;
    logic [7:0] tmo;

    logic [3:0] xmax;
    logic [1:0] rot_last;
    logic [3:0] nxt_x;
    logic [1:0] nxt_rot;
    logic       more;

    function automatic logic [3:0] piece_w(input logic [2:0] s, input logic [1:0] r);
        case (s)
            3'd0:    return r[0] ? 4'd1 : 4'd4;
            3'd1:    return 4'd2;
            default: return r[0] ? 4'd2 : 4'd3;
        endcase
    endfunction

    function automatic logic [1:0] piece_rot_last(input logic [2:0] s);
        case (s)
            3'd1:                return 2'd0;
            3'd0, 3'd2, 3'd3:    return 2'd1;
            default:             return 2'd3;
        endcase
    endfunction

    // Next placement in walk order: X first, then rotation.
    always_comb begin
        xmax     = 4'(NUM_X) - piece_w(shape_r, rot);
        rot_last = piece_rot_last(shape_r);
        nxt_x    = x + 4'd1;
        nxt_rot  = rot;
        more     = 1'b1;
        if (x >= xmax) begin
            nxt_x = 4'd0;
            if (rot < rot_last) begin
                nxt_rot = rot + 2'd1;
            end else begin
                more = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            shape_r         <= 3'd0;
            rot             <= 2'd0;
            x               <= 4'd0;
            tmo             <= 8'd0;
            mmu_start       <= 1'b0;
            cand_blockX     <= 4'd0;
            cand_block_type <= 5'd0;
            ofm_clear       <= 1'b0;
            busy            <= 1'b0;
            sched_done      <= 1'b0;
            err             <= 1'b0;
            cand_count      <= 6'd0;
        end else begin
            mmu_start  <= 1'b0;
            ofm_clear  <= 1'b0;
            sched_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shape_r    <= shape_i;
                        err        <= 1'b0;
                        cand_count <= 6'd0;
                        rot        <= 2'd0;
                        x          <= 4'd0;
                        busy       <= 1'b1;
                        ofm_clear  <= (shape_i != 3'd7);
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (shape_r == 3'd7) begin
                        err        <= 1'b1;
                        sched_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        mmu_start       <= 1'b1;
                        cand_blockX     <= x;
                        cand_block_type <= {shape_r, rot};
                        tmo             <= 8'd0;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (mmu_done) begin
                        if (cand_count != 6'h3F) begin
                            cand_count <= cand_count + 6'd1;
                        end
                        state <= S_NEXT;
                    end else if (tmo == 8'(TIMEOUT - 1)) begin
                        err        <= 1'b1;
                        sched_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
                S_NEXT: begin
                    if (more) begin
                        x               <= nxt_x;
                        rot             <= nxt_rot;
                        mmu_start       <= 1'b1;
                        cand_blockX     <= nxt_x;
                        cand_block_type <= {shape_r, nxt_rot};
                        tmo             <= 8'd0;
                        state           <= S_ISSUE;
                    end else begin
                        sched_done <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t01_ai_cand_sched.sv
// tb/tb_t01_ai_cand_sched.sv - directed self-checking bench for t01_ai_cand_sched
module tb_t01_ai_cand_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] shape_i;
    logic       mmu_done;
    logic       mmu_start;
    logic [3:0] cand_blockX;
    logic [4:0] cand_block_type;
    logic       ofm_clear;
    logic       busy;
    logic       sched_done;
    logic       err;
    logic [5:0] cand_count;

    t01_ai_cand_sched #(.NUM_X(10), .TIMEOUT(255)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .shape_i         (shape_i),
        .mmu_done        (mmu_done),
        .mmu_start       (mmu_start),
        .cand_blockX     (cand_blockX),
        .cand_block_type (cand_block_type),
        .ofm_clear       (ofm_clear),
        .busy            (busy),
        .sched_done      (sched_done),
        .err             (err),
        .cand_count      (cand_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int n_issue, n_clear, clear_cyc, first_issue, done_cyc, done_err, done_cnt;
    int busy_low, err_at_clear, done_prev_err, n_done_seen;
    int exp_x[$];
    int exp_t[$];

    // Piece widths per rotation (I,O,S,Z,T,L,J,invalid) and rotation counts.
    int w_tab[8][4] = '{'{4,1,4,1}, '{2,2,2,2}, '{3,2,3,2}, '{3,2,3,2},
                        '{3,2,3,2}, '{3,2,3,2}, '{3,2,3,2}, '{0,0,0,0}};
    int nrot_tab[8] = '{2, 1, 2, 2, 4, 4, 4, 0};

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sched_done"}, sched_done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cand_count"}, cand_count, 0);
        check({tag, "_mmu_start"}, mmu_start, 0);
        check({tag, "_ofm_clear"}, ofm_clear, 0);
        check({tag, "_cand_blockX"}, cand_blockX, 0);
        check({tag, "_cand_block_type"}, cand_block_type, 0);
    endtask

    // Runs one search acting as the MMU, answering k cycles after each mmu_start
    // (k=0: never answer). abort_n>0 asserts rst in the WAIT after the abort_n-th issue.
    task automatic run_search(input logic [2:0] s, input int k, input int mid_start,
                              input int stray, input int abort_n, input int limit);
        int cyc;
        int cnt;
        int prev_err;
        n_issue = 0; n_clear = 0; clear_cyc = -1; first_issue = -1;
        done_cyc = -1; done_err = -1; done_cnt = -1; busy_low = 0;
        err_at_clear = -1; done_prev_err = -1;
        exp_x.delete();
        exp_t.delete();
        for (int r = 0; r < nrot_tab[s]; r++) begin
            for (int xx = 0; xx <= 10 - w_tab[s][r]; xx++) begin
                exp_x.push_back(xx);
                exp_t.push_back(int'(s) * 4 + r);
            end
        end
        @(negedge clk);
        start = 1'b1;
        shape_i = s;
        mmu_done = 1'b0;
        cyc = 0;
        cnt = 0;
        prev_err = 0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            start = (mid_start != 0 && cyc == mid_start);
            mmu_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) mmu_done = 1'b1;
            end
            if (busy !== 1'b1) busy_low++;
            if (cyc == 1) err_at_clear = err;
            if (ofm_clear === 1'b1) begin
                n_clear++;
                clear_cyc = cyc;
            end
            if (mmu_start === 1'b1) begin
                if (n_issue == 0) first_issue = cyc;
                if (n_issue < exp_x.size()) begin
                    check("cand_blockX", cand_blockX, exp_x[n_issue]);
                    check("cand_block_type", cand_block_type, exp_t[n_issue]);
                end
                n_issue++;
                if (k > 0) cnt = k;
                if (stray != 0) mmu_done = 1'b1;
            end else if (abort_n != 0 && n_issue == abort_n) begin
                rst = 1'b1;
                mmu_done = 1'b0;
                start = 1'b0;
                return;
            end
            if (sched_done === 1'b1) begin
                done_cyc = cyc;
                done_err = err;
                done_cnt = cand_count;
                done_prev_err = prev_err;
                break;
            end
            prev_err = err;
        end
        start = 1'b0;
        mmu_done = 1'b0;
        check("sched_done_within_bound", int'(done_cyc >= 0), 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        shape_i = 3'd0;
        mmu_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Stray mmu_done while idle
        mmu_done = 1'b1;
        @(negedge clk);
        mmu_done = 1'b0;
        @(negedge clk);
        check("idle_stray_count", cand_count, 0);
        check("idle_stray_busy", busy, 0);

        // O piece, MMU answers 3 cycles after each mmu_start
        run_search(3'd1, 3, 0, 0, 0, 200);
        check("o_count", done_cnt, 9);
        check("o_issues", n_issue, 9);
        check("o_clears", n_clear, 1);
        check("o_clear_cycle", clear_cyc, 1);
        check("o_first_issue", first_issue, 2);
        check("o_issue_to_done", done_cyc - first_issue, 45);
        check("o_start_to_done", done_cyc, 47);
        check("o_err", done_err, 0);
        check("o_busy_low", busy_low, 0);
        @(negedge clk);
        check("o_idle_busy", busy, 0);
        check("o_idle_done", sched_done, 0);
        check("o_hold_x", cand_blockX, 8);
        check("o_hold_type", cand_block_type, 5'b00100);

        // T piece, fastest MMU
        run_search(3'd4, 1, 0, 0, 0, 1000);
        check("t_count", done_cnt, 34);
        check("t_issues", n_issue, 34);
        check("t_err", done_err, 0);

        // I piece
        run_search(3'd0, 2, 0, 0, 0, 1000);
        check("i_count", done_cnt, 17);
        check("i_issues", n_issue, 17);

        // MMU never answers
        run_search(3'd2, 0, 0, 0, 0, 600);
        check("to_issues", n_issue, 1);
        check("to_latency", done_cyc - first_issue, 256);
        check("to_err", done_err, 1);
        check("to_err_before", done_prev_err, 0);
        check("to_count", done_cnt, 0);
        @(negedge clk);
        check("to_err_held", err, 1);

        // Z piece: clears err, mid-search start and stray mmu_done in ISSUE ignored
        run_search(3'd3, 2, 6, 1, 0, 1000);
        check("z_err_cleared", err_at_clear, 0);
        check("z_count", done_cnt, 17);
        check("z_issues", n_issue, 17);
        check("z_err", done_err, 0);

        // Invalid shape
        run_search(3'd7, 3, 0, 0, 0, 50);
        check("bad_done_cycle", done_cyc, 2);
        check("bad_err", done_err, 1);
        check("bad_issues", n_issue, 0);
        check("bad_clears", n_clear, 0);
        check("bad_count", done_cnt, 0);

        // Reset during WAIT of the 5th candidate
        run_search(3'd4, 3, 0, 0, 5, 500);
        check("abort_issues", n_issue, 5);
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        n_done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (sched_done === 1'b1) n_done_seen++;
        end
        check("abort_no_done", n_done_seen, 0);
        run_search(3'd1, 3, 0, 0, 0, 200);
        check("post_abort_count", done_cnt, 9);
        check("post_abort_err", done_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
